// File: rtl/div_mon_pkg.sv
// rtl/div_mon_pkg.sv - shared state type for the strobe period monitor
// Purpose: holds the monitor state encoding shared by the top and any users.
// Contents: mon_state_t {IDLE, ACQ, LOCK}.
package div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } mon_state_t;

endpackage

// File: rtl/interval_counter.sv
// rtl/interval_counter.sv - saturating interval counter with clear and load-to-one
// Purpose: counts clk cycles since the last strobe event.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   clr   - clear to 0 (highest priority)
//   load1 - load 1 (an event occurred this cycle)
//   inc   - increment by 1, saturating at 2^W-1
//   cnt   - current count
module interval_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= W'(1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/strobe_period_monitor.sv
// rtl/strobe_period_monitor.sv - lock detector for a periodic one-cycle strobe
// Purpose: measures the interval between strobe events, locks after LOCK_CNT
//   consecutive intervals equal to DIV, and pulses err when lock is lost.
// Configuration macro: PERIOD_CAPTURE_EN adds the period output.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   en     - monitor enable; low forces IDLE
//   strobe - one event per high cycle
//   locked - high while in LOCK
//   err    - one-cycle pulse after any LOCK exit (not for en=0 or reset)
//   period - last interval seen at a strobe in ACQ/LOCK (PERIOD_CAPTURE_EN only)
module strobe_period_monitor
  import div_mon_pkg::*;
#(
  parameter int DIV      = 3,
  parameter int W        = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         strobe,
  output logic         locked,
  output logic         err
`ifdef PERIOD_CAPTURE_EN
  ,
  output logic [W-1:0] period
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  DIV_W  = W'(DIV);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);

  if ((DIV < 2) || (DIV > (2 ** W) - 1) || (LOCK_CNT < 1)) begin : g_bad_params
    $error("strobe_period_monitor: illegal DIV/W/LOCK_CNT combination");
  end

  mon_state_t    state, state_nxt;
  logic [W-1:0]  cnt;
  logic [MW-1:0] mcnt, mcnt_nxt, mcnt_inc;
  logic          cnt_clr, cnt_load1, cnt_inc;
  logic          err_nxt;
  logic          at_div;

  assign at_div   = (cnt == DIV_W);
  assign mcnt_inc = mcnt + MW'(1);

  interval_counter #(.W(W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      mcnt_nxt  = '0;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          mcnt_nxt = '0;
          if (strobe) begin
            state_nxt = ACQ;
            cnt_load1 = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        ACQ: begin
          if (strobe) begin
            cnt_load1 = 1'b1;
            if (at_div) begin
              mcnt_nxt = mcnt_inc;
              if (mcnt_inc == LOCK_M) state_nxt = LOCK;
            end else begin
              mcnt_nxt = '0;
            end
          end else if (at_div) begin
            // The expected event did not arrive: start over.
            state_nxt = IDLE;
            mcnt_nxt  = '0;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LOCK: begin
          if (strobe) begin
            cnt_load1 = 1'b1;
            if (!at_div) begin
              state_nxt = ACQ;
              mcnt_nxt  = '0;
            end
          end else if (at_div) begin
            state_nxt = IDLE;
            mcnt_nxt  = '0;
            cnt_clr   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          mcnt_nxt  = '0;
          cnt_clr   = 1'b1;
        end
      endcase
    end
    // Disabling the monitor is a deliberate exit, not a lock loss.
    err_nxt = en && (state == LOCK) && (state_nxt != LOCK);
  end

  assign locked = (state == LOCK);

`ifdef PERIOD_CAPTURE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period <= '0;
    end else if (en && strobe && (state != IDLE)) begin
      period <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_strobe_period_monitor.sv
// tb/tb_strobe_period_monitor.sv - self-checking bench for strobe_period_monitor
module tb_strobe_period_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic en, strobe, locked, err;
  logic sat_en, sat_strobe, sat_locked, sat_err;
  logic cap_en, cap_strobe, cap_locked, cap_err;
`ifdef PERIOD_CAPTURE_EN
  logic [7:0] period;
  logic [1:0] sat_period;
  logic [7:0] cap_period;
`endif

  strobe_period_monitor #(.DIV(3), .W(8), .LOCK_CNT(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .strobe(strobe),
    .locked(locked), .err(err)
`ifdef PERIOD_CAPTURE_EN
    , .period(period)
`endif
  );

  strobe_period_monitor #(.DIV(3), .W(2), .LOCK_CNT(4)) u_sat (
    .clk(clk), .reset(reset), .en(sat_en), .strobe(sat_strobe),
    .locked(sat_locked), .err(sat_err)
`ifdef PERIOD_CAPTURE_EN
    , .period(sat_period)
`endif
  );

  strobe_period_monitor #(.DIV(5), .W(8), .LOCK_CNT(4)) u_cap (
    .clk(clk), .reset(reset), .en(cap_en), .strobe(cap_strobe),
    .locked(cap_locked), .err(cap_err)
`ifdef PERIOD_CAPTURE_EN
    , .period(cap_period)
`endif
  );

  typedef struct {
    logic en;
    logic strobe;
    logic locked;
    logic err;
  } vec_t;

  typedef struct {
    logic locked;
    logic err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input logic e, input logic s, input logic l, input logic r);
    vec_t v;
    v.en = e; v.strobe = s; v.locked = l; v.err = r;
    vecs.push_back(v);
  endtask

  // One DIV=3 interval: two quiet cycles then the strobe.
  task automatic add_interval(input logic lk_mid, input logic lk_end);
    add(1'b1, 1'b0, lk_mid, 1'b0);
    add(1'b1, 1'b0, lk_mid, 1'b0);
    add(1'b1, 1'b1, lk_end, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    // Steady lock from IDLE, then a missing pulse.
    add(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add_interval(1'b0, 1'b0);
    add_interval(1'b0, 1'b1);
    add_interval(1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0);
    // Back-to-back strobes in ACQ, relock, then an early pulse and relock.
    add(1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add_interval(1'b0, 1'b0);
    add_interval(1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) add_interval(1'b0, 1'b0);
    add_interval(1'b0, 1'b1);
    // en=0 with a concurrent strobe while locked.
    add(1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0);

    reset = 1'b0;
    en = 1'b0; strobe = 1'b0;
    sat_en = 1'b1; sat_strobe = 1'b0;
    cap_en = 1'b1; cap_strobe = 1'b0;
    #1;
    check("reset_locked", locked, 1'b0);
    check("reset_err", err, 1'b0);
`ifdef PERIOD_CAPTURE_EN
    check("reset_period", period, 8'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en     = vecs[i].en;
      strobe = vecs[i].strobe;
      e.locked = vecs[i].locked;
      e.err    = vecs[i].err;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_locked", i), locked, e.locked);
      check($sformatf("vec%0d_err", i), err, e.err);
    end

    // Async reset while locked: outputs drop before any edge, no err after release.
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      strobe = ((i % 3) == 0);
      tick();
    end
    strobe = 1'b0;
    check("pre_reset_locked", locked, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_locked", locked, 1'b0);
    check("async_reset_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_reset%0d_err", i), err, 1'b0);
      check($sformatf("post_reset%0d_locked", i), locked, 1'b0);
    end

    // W=2, DIV=3: silence in ACQ must fall back to IDLE at cnt==DIV, no err.
    sat_strobe = 1'b1;
    tick();
    sat_strobe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("sat_quiet%0d_err", i), sat_err, 1'b0);
      check($sformatf("sat_quiet%0d_locked", i), sat_locked, 1'b0);
    end
    // From IDLE this strobe only starts acquisition; a stuck ACQ would count it.
    sat_strobe = 1'b1;
    tick();
`ifdef PERIOD_CAPTURE_EN
    check("sat_period_idle", sat_period, 2'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      sat_strobe = 1'b0;
      tick();
      tick();
      sat_strobe = 1'b1;
      tick();
      check($sformatf("sat_int%0d_locked", k), sat_locked, (k == 3));
`ifdef PERIOD_CAPTURE_EN
      check($sformatf("sat_int%0d_period", k), sat_period, 2'd3);
`endif
    end
    sat_strobe = 1'b0;

    // DIV=5 capture: strobe intervals 3, 5, 3.
    cap_strobe = 1'b1;
    tick();
`ifdef PERIOD_CAPTURE_EN
    check("cap_period_idle", cap_period, 8'd0);
`endif
    begin
      int gaps[3];
      gaps[0] = 3; gaps[1] = 5; gaps[2] = 3;
      for (int k = 0; k < 3; k++) begin
        cap_strobe = 1'b0;
        for (int c = 1; c < gaps[k]; c++) tick();
        cap_strobe = 1'b1;
        tick();
        check($sformatf("cap_int%0d_err", k), cap_err, 1'b0);
        check($sformatf("cap_int%0d_locked", k), cap_locked, 1'b0);
`ifdef PERIOD_CAPTURE_EN
        check($sformatf("cap_int%0d_period", k), cap_period, 32'(gaps[k]));
`endif
      end
    end
    cap_strobe = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/strobe_period_monitor.md
STROBE_PERIOD_MONITOR -- requirements
Module: strobe_period_monitor

Interface
REQ-001 Parameters SHALL be, one per line:
- DIV, default 3: expected strobe period in clk cycles.
- W, default 8: interval counter width.
- LOCK_CNT, default 4: consecutive good intervals required to lock.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  sole clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  monitor enable.
- strobe  input  1  one-cycle-per-period pulse from a divide-by-N FSM; each high cycle is one event.
- locked  output  1  high while in LOCK.
- err  output  1  one-cycle pulse on loss of lock.
- period  output  W  last measured interval; present only under the configuration macro.
REQ-003 Legal parameters SHALL be 2 <= DIV <= 2^W-1 and LOCK_CNT >= 1; elaboration SHALL fail otherwise.

Function
REQ-004 State SHALL be one of IDLE, ACQ, LOCK, plus interval counter cnt (W bits) and match counter mcnt (0..LOCK_CNT).
REQ-005 In IDLE, cnt and mcnt SHALL hold 0. On strobe=1, next state SHALL be ACQ, cnt SHALL load 1 and mcnt SHALL load 0.
REQ-006 In ACQ or LOCK with strobe=0, cnt SHALL increment by 1, saturating at 2^W-1.
REQ-007 In ACQ with strobe=1 and cnt==DIV, mcnt SHALL increment and cnt SHALL load 1; if mcnt+1==LOCK_CNT, next state SHALL be LOCK.
REQ-008 In ACQ with strobe=1 and cnt!=DIV, mcnt SHALL clear, cnt SHALL load 1, the state SHALL remain ACQ, and no err SHALL be raised.
REQ-009 In ACQ or LOCK with strobe=0 and cnt==DIV (missing pulse), next state SHALL be IDLE.
REQ-010 In LOCK with strobe=1 and cnt==DIV, the state SHALL remain LOCK and cnt SHALL load 1.
REQ-011 In LOCK with strobe=1 and cnt!=DIV (early pulse), next state SHALL be ACQ, mcnt SHALL clear and cnt SHALL load 1.
REQ-012 err SHALL be a registered pulse, high for exactly the one cycle after any LOCK exit; it SHALL never be raised from IDLE or ACQ.
REQ-013 locked SHALL be decoded combinationally from the state register (state==LOCK), with no additional latency.
REQ-014 en=0 SHALL force IDLE and clear cnt and mcnt on the next edge, with no err; en=0 SHALL take priority over a simultaneous strobe.
REQ-015 Back-to-back strobe cycles SHALL count as interval 1 and be evaluated per REQ-007, REQ-008 and REQ-011.

Reset
REQ-016 reset=0 SHALL asynchronously set state=IDLE, cnt=0, mcnt=0, locked=0, err=0 and period=0.
REQ-017 Reset deassertion SHALL take effect at the first rising clk edge after release; reset asserted mid-lock SHALL NOT produce an err pulse.

Configuration
REQ-018 With macro PERIOD_CAPTURE_EN defined, output period SHALL exist and SHALL load cnt on every strobe=1 cycle in ACQ or LOCK (not in IDLE).
REQ-019 Without PERIOD_CAPTURE_EN, the period port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-020 The state enum typedef mon_state_t {IDLE, ACQ, LOCK} (2-bit logic) SHALL live in shared package div_mon_pkg.
REQ-021 The saturating load/increment counter SHALL be one sub-module, interval_counter (parameter W; inputs clk, reset, clr, load1, inc; output cnt).

Verification
REQ-022 Bench scenario, steady lock: DIV=3, LOCK_CNT=4, strobe every 3rd cycle from cycle 0 -> locked rises on the edge of the 5th strobe (4 good intervals), err stays 0.
REQ-023 Bench scenario, missing pulse: locked, then strobe omitted at the expected cycle -> state IDLE next edge, err=1 for exactly 1 cycle, locked=0.
REQ-024 Bench scenario, early pulse: locked, strobe arrives with cnt=2 -> state ACQ, err pulse 1 cycle; 4 further good intervals -> relock.
REQ-025 Bench scenario, enable priority: en=0 concurrent with a strobe while locked -> IDLE, locked=0, err=0.
REQ-026 Bench scenario, async reset: reset pulled low between edges while locked -> locked=0 immediately, with no err after release.
REQ-027 Bench scenario, capture: with PERIOD_CAPTURE_EN, strobes at intervals 3,5,3 -> period reads 3,5,3; W=2 with no strobe for 10 cycles in ACQ -> IDLE at cnt==DIV and no err.
